icache_line_fill: RTL and testbench



---
 rtl/icache_line_fill.sv | 149 ++++++++++++++
 tb/tb_icache_line_fill.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_line_fill.sv
// Instruction-cache line-fill controller.
// On a miss, reads one full line from memory one word per handshake, writes each
// word into the cache data memory, then writes the tag/valid entry and pulses done.
// Ports:
//   i_clock, i_reset       : clock and synchronous active-high reset
//   i_miss, i_addr         : miss request and missing byte address (sampled in IDLE)
//   o_busy, o_done         : fill in progress / one-cycle completion pulse
//   o_mem_rd, o_mem_addr   : memory read request and word-aligned address
//   i_mem_ack, i_mem_data  : memory read acknowledge and data
//   o_cache_wr/addr/data   : data memory write port ({index, word})
//   o_tag_wr/index, o_tag  : tag memory write port (valid bit implied 1)
module icache_line_fill #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned INDEX_WIDTH  = 5,
  parameter int unsigned OFFSET_WIDTH = 2,
  localparam int unsigned TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH - 2
) (
  input  logic                              i_clock,
  input  logic                              i_reset,
  input  logic                              i_miss,
  input  logic [ADDR_WIDTH-1:0]             i_addr,
  output logic                              o_busy,
  output logic                              o_done,
  output logic                              o_mem_rd,
  output logic [ADDR_WIDTH-1:0]             o_mem_addr,
  input  logic                              i_mem_ack,
  input  logic [DATA_WIDTH-1:0]             i_mem_data,
  output logic                              o_cache_wr,
  output logic [INDEX_WIDTH+OFFSET_WIDTH-1:0] o_cache_addr,
  output logic [DATA_WIDTH-1:0]             o_cache_data,
  output logic                              o_tag_wr,
  output logic [INDEX_WIDTH-1:0]            o_tag_index,
  output logic [TAG_WIDTH-1:0]              o_tag
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_TAG   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [OFFSET_WIDTH-1:0] cnt_q, cnt_d;
  logic [TAG_WIDTH-1:0]    tag_q, tag_d;
  logic [INDEX_WIDTH-1:0]  idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;

  logic                              busy_d, done_d, mem_rd_d, cache_wr_d, tag_wr_d;
  logic [ADDR_WIDTH-1:0]             mem_addr_d;
  logic [INDEX_WIDTH+OFFSET_WIDTH-1:0] cache_addr_d;
  logic [DATA_WIDTH-1:0]             cache_data_d;
  logic [INDEX_WIDTH-1:0]            tag_index_d;
  logic [TAG_WIDTH-1:0]              tag_out_d;

  // Word-offset and byte bits of the miss address are not needed: fills start at word 0.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, i_addr[OFFSET_WIDTH+1:0]};

  // Next-state, datapath and next-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tag_d   = tag_q;
    idx_d   = idx_q;
    data_d  = data_q;

    case (state_q)
      S_IDLE: begin
        if (i_miss) begin
          tag_d   = i_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
          idx_d   = i_addr[OFFSET_WIDTH+2 +: INDEX_WIDTH];
          cnt_d   = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (i_mem_ack) begin
          data_d  = i_mem_data;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (cnt_q == '1) begin
          state_d = S_TAG;
        end else begin
          cnt_d   = cnt_q + OFFSET_WIDTH'(1);
          state_d = S_READ;
        end
      end
      S_TAG:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are a pure function of the upcoming state, so registering them
    // gives state-decoded strobes that are zero outside their own state.
    busy_d       = (state_d != S_IDLE);
    mem_rd_d     = (state_d == S_READ);
    cache_wr_d   = (state_d == S_WRITE);
    tag_wr_d     = (state_d == S_TAG);
    done_d       = (state_d == S_DONE);
    mem_addr_d   = mem_rd_d   ? {tag_d, idx_d, cnt_d, 2'b00} : '0;
    cache_addr_d = cache_wr_d ? {idx_d, cnt_d}               : '0;
    cache_data_d = cache_wr_d ? data_d                       : '0;
    tag_index_d  = tag_wr_d   ? idx_d                        : '0;
    tag_out_d    = tag_wr_d   ? tag_d                        : '0;
  end

  // State, datapath and output registers; reset aborts any fill in progress.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      tag_q        <= '0;
      idx_q        <= '0;
      data_q       <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_mem_rd     <= 1'b0;
      o_mem_addr   <= '0;
      o_cache_wr   <= 1'b0;
      o_cache_addr <= '0;
      o_cache_data <= '0;
      o_tag_wr     <= 1'b0;
      o_tag_index  <= '0;
      o_tag        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tag_q        <= tag_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      o_busy       <= busy_d;
      o_done       <= done_d;
      o_mem_rd     <= mem_rd_d;
      o_mem_addr   <= mem_addr_d;
      o_cache_wr   <= cache_wr_d;
      o_cache_addr <= cache_addr_d;
      o_cache_data <= cache_data_d;
      o_tag_wr     <= tag_wr_d;
      o_tag_index  <= tag_index_d;
      o_tag        <= tag_out_d;
    end
  end

endmodule

// File: tb/tb_icache_line_fill.sv
// Bench for icache_line_fill: directed fills with a scoreboard of expected
// memory reads, cache writes, tag writes and done-cycle numbers.
module tb_icache_line_fill;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_miss;
  logic [31:0] i_addr;
  logic        o_busy, o_done, o_mem_rd;
  logic [31:0] o_mem_addr;
  logic        i_mem_ack;
  logic [31:0] i_mem_data;
  logic        o_cache_wr;
  logic [6:0]  o_cache_addr;
  logic [31:0] o_cache_data;
  logic        o_tag_wr;
  logic [4:0]  o_tag_index;
  logic [22:0] o_tag;

  icache_line_fill dut (
    .i_clock(clk), .i_reset(i_reset), .i_miss(i_miss), .i_addr(i_addr),
    .o_busy(o_busy), .o_done(o_done), .o_mem_rd(o_mem_rd), .o_mem_addr(o_mem_addr),
    .i_mem_ack(i_mem_ack), .i_mem_data(i_mem_data),
    .o_cache_wr(o_cache_wr), .o_cache_addr(o_cache_addr), .o_cache_data(o_cache_data),
    .o_tag_wr(o_tag_wr), .o_tag_index(o_tag_index), .o_tag(o_tag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vec  = 0;
  int errs = 0;

  logic [31:0] rd_q[$];
  logic [38:0] wr_q[$];
  logic [27:0] tag_q[$];
  int          done_q[$];

  int wait_n = 0;
  bit spur   = 1'b0;
  int wcnt   = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  // Memory responder: acks after wait_n stall cycles; optional junk acks outside reads.
  always @(negedge clk) begin
    if (o_mem_rd) begin
      if (wcnt >= wait_n) begin
        i_mem_ack  = 1'b1;
        i_mem_data = mem_word(o_mem_addr);
        wcnt       = 0;
      end else begin
        i_mem_ack  = 1'b0;
        i_mem_data = 32'h0;
        wcnt       = wcnt + 1;
      end
    end else begin
      i_mem_ack  = spur;
      i_mem_data = spur ? 32'hDEADBEEF : 32'h0;
      wcnt       = 0;
    end
  end

  // Monitor: compares every presented output against the scoreboard queues.
  always @(negedge clk) begin
    logic [38:0] ew;
    logic [27:0] et;
    int          ed;
    if (o_mem_rd) begin
      vec++;
      if (rd_q.size() == 0) begin
        errs++; $display("FAIL mem_addr unexpected read got %h", o_mem_addr);
      end else if (o_mem_addr !== rd_q[0]) begin
        errs++; $display("FAIL mem_addr got %h exp %h", o_mem_addr, rd_q[0]);
      end
    end
    if (o_cache_wr) begin
      vec++;
      if (wr_q.size() == 0) begin
        errs++; $display("FAIL cache_wr unexpected write got %h/%h", o_cache_addr, o_cache_data);
      end else begin
        ew = wr_q.pop_front();
        if ({o_cache_addr, o_cache_data} !== ew) begin
          errs++; $display("FAIL cache_wr got %h/%h exp %h/%h", o_cache_addr, o_cache_data, ew[38:32], ew[31:0]);
        end
      end
      if (rd_q.size() > 0) void'(rd_q.pop_front());
    end
    if (o_tag_wr) begin
      vec++;
      if (tag_q.size() == 0) begin
        errs++; $display("FAIL tag_wr unexpected got %h/%h", o_tag_index, o_tag);
      end else begin
        et = tag_q.pop_front();
        if ({o_tag_index, o_tag} !== et) begin
          errs++; $display("FAIL tag_wr got %h/%h exp %h/%h", o_tag_index, o_tag, et[27:23], et[22:0]);
        end
      end
    end
    if (o_done) begin
      vec++;
      if (done_q.size() == 0) begin
        errs++; $display("FAIL done unexpected at cycle %0d", cyc);
      end else begin
        ed = done_q.pop_front();
        if (cyc != ed) begin
          errs++; $display("FAIL done_cycle got %0d exp %0d", cyc, ed);
        end
      end
    end
  end

  task automatic expect_line(input logic [31:0] mbase, input logic [6:0] cbase,
                             input logic [4:0] idx, input logic [22:0] tag);
    for (int w = 0; w < 4; w++) begin
      rd_q.push_back(mbase + 32'(4 * w));
      wr_q.push_back({cbase + 7'(w), mem_word(mbase + 32'(4 * w))});
    end
    tag_q.push_back({idx, tag});
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_done && n < 200);
    if (!o_done) begin
      vec++; errs++;
      $display("FAIL %s timeout waiting for done", name);
    end
  endtask

  task automatic check_idle(input string name);
    vec++;
    if ({o_busy, o_done, o_mem_rd, o_mem_addr, o_cache_wr, o_cache_addr, o_cache_data,
         o_tag_wr, o_tag_index, o_tag} !== '0) begin
      errs++;
      $display("FAIL %s outputs not zero busy=%b rd=%b wr=%b tagwr=%b done=%b addr=%h",
               name, o_busy, o_mem_rd, o_cache_wr, o_tag_wr, o_done, o_mem_addr);
    end
  endtask

  task automatic run_fill(input string name, input logic [31:0] addr, input int waits,
                          input logic [31:0] mbase, input logic [6:0] cbase,
                          input logic [4:0] idx, input logic [22:0] tag, input int lat);
    wait_n = waits;
    expect_line(mbase, cbase, idx, tag);
    @(negedge clk);
    i_addr = addr;
    i_miss = 1'b1;
    done_q.push_back(cyc + lat);
    wait_done(name);
    i_miss = 1'b0;
  endtask

  initial begin
    i_reset    = 1'b1;
    i_miss     = 1'b0;
    i_addr     = 32'h0;
    i_mem_ack  = 1'b0;
    i_mem_data = 32'h0;
    repeat (2) @(negedge clk);
    check_idle("reset_state");
    i_reset = 1'b0;
    repeat (2) @(negedge clk);

    // Zero-wait fill of 0x1234: index 0x03, tag 0x000009.
    run_fill("zero_wait", 32'h0000_1234, 0, 32'h0000_1230, 7'h0C, 5'h03, 23'h000009, 10);
    @(negedge clk);
    check_idle("after_zero_wait");

    // Three wait states per word: index 0x17, tag 0x007FFF.
    run_fill("wait_states", 32'h00FF_FF70, 3, 32'h00FF_FF70, 7'h5C, 5'h17, 23'h007FFF, 22);

    // Miss pulsed to 0x8000 mid-fill of 0x4560 must be ignored (index 0x16, tag 0x22).
    wait_n = 0;
    expect_line(32'h0000_4560, 7'h58, 5'h16, 23'h000022);
    @(negedge clk);
    i_addr = 32'h0000_4560;
    i_miss = 1'b1;
    done_q.push_back(cyc + 10);
    repeat (3) @(negedge clk);
    i_miss = 1'b0; i_addr = 32'h0000_8000;
    @(negedge clk);
    i_miss = 1'b1;
    @(negedge clk);
    i_addr = 32'h0000_4560;
    wait_done("miss_busy");
    i_miss = 1'b0;

    // Spurious acks in IDLE/WRITE/TAG carrying 0xDEADBEEF; one wait per word.
    spur = 1'b1;
    repeat (3) @(negedge clk);
    run_fill("spurious_ack", 32'h0000_0ABC, 1, 32'h0000_0AB0, 7'h2C, 5'h0B, 23'h000005, 14);
    repeat (3) @(negedge clk);
    spur = 1'b0;
    @(negedge clk);
    check_idle("after_spurious");

    // Back-to-back: 0x0 then 0x200 accepted in the first IDLE cycle after done.
    wait_n = 0;
    expect_line(32'h0000_0000, 7'h00, 5'h00, 23'h000000);
    expect_line(32'h0000_0200, 7'h00, 5'h00, 23'h000001);
    @(negedge clk);
    i_addr = 32'h0000_0000;
    i_miss = 1'b1;
    done_q.push_back(cyc + 10);
    wait_done("b2b_first");
    i_addr = 32'h0000_0200;
    done_q.push_back(cyc + 11);
    wait_done("b2b_second");
    i_miss = 1'b0;
    repeat (2) @(negedge clk);

    // Reset right after word 1 is written: only words 0 and 1 land, no tag write.
    wait_n = 0;
    rd_q.push_back(32'h0000_1230); wr_q.push_back({7'h0C, mem_word(32'h0000_1230)});
    rd_q.push_back(32'h0000_1234); wr_q.push_back({7'h0D, mem_word(32'h0000_1234)});
    @(negedge clk);
    i_addr = 32'h0000_1234;
    i_miss = 1'b1;
    repeat (4) @(negedge clk);
    i_reset = 1'b1;
    i_miss  = 1'b0;
    @(negedge clk);
    check_idle("reset_mid_fill");
    i_reset = 1'b0;
    repeat (15) @(negedge clk);
    check_idle("after_reset_fill");

    vec++;
    if (rd_q.size() != 0 || wr_q.size() != 0 || tag_q.size() != 0 || done_q.size() != 0) begin
      errs++;
      $display("FAIL leftover rd=%0d wr=%0d tag=%0d done=%0d exp all 0",
               rd_q.size(), wr_q.size(), tag_q.size(), done_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached");
    $fatal(1, "timeout");
  end

endmodule
